// File: rtl/bias_add_row_seq_if.sv
// rtl/bias_add_row_seq_if.sv - row request, result row and adder-driver handshake bundle
interface bias_add_row_seq_if #(
    parameter int N_COL = 8
) ();
    logic               in_valid;
    logic               in_ready;
    logic [32*N_COL-1:0] in_acc;
    logic [32*N_COL-1:0] in_bias;
    logic               in_bias_en;
    logic               out_valid;
    logic               out_ready;
    logic [32*N_COL-1:0] out_data;
    logic               add_start;
    logic [31:0]        add_a;
    logic [31:0]        add_b;
    logic               add_busy;
    logic               add_done;
    logic [31:0]        add_z;

    modport master (
        output in_valid, in_acc, in_bias, in_bias_en, out_ready, add_busy, add_done, add_z,
        input  in_ready, out_valid, out_data, add_start, add_a, add_b
    );

    modport slave (
        input  in_valid, in_acc, in_bias, in_bias_en, out_ready, add_busy, add_done, add_z,
        output in_ready, out_valid, out_data, add_start, add_a, add_b
    );
endinterface

// File: rtl/bias_add_row_seq.sv
// rtl/bias_add_row_seq.sv - issues acc+bias lane adds one at a time to a shared FP32 adder driver
module bias_add_row_seq #(
    parameter int N_COL = 8,
    parameter int IDX_W = $clog2(N_COL) + 1
) (
    input logic               clk,
    input logic               rst,
    bias_add_row_seq_if.slave bus
);
    localparam int SEL_W = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_COL - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, OUT} state_t;

    state_t           state;
    logic [IDX_W-1:0] lane;
    logic [SEL_W-1:0] sel;
    logic [31:0]      acc_r   [N_COL];
    logic [31:0]      bias_r  [N_COL];
    logic [31:0]      out_buf [N_COL];
    logic             out_valid;
    logic             add_start;
    logic [31:0]      add_a;
    logic [31:0]      add_b;

    assign sel           = lane[SEL_W-1:0];
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid;
    assign bus.add_start = add_start;
    assign bus.add_a     = add_a;
    assign bus.add_b     = add_b;

    for (genvar g = 0; g < N_COL; g++) begin : g_pack
        assign bus.out_data[32*g +: 32] = out_buf[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lane      <= '0;
            out_valid <= 1'b0;
            add_start <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            for (int i = 0; i < N_COL; i++) out_buf[i] <= '0;
        end else begin
            add_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        lane <= '0;
                        for (int i = 0; i < N_COL; i++) begin
                            acc_r[i]  <= bus.in_acc[32*i +: 32];
                            bias_r[i] <= bus.in_bias[32*i +: 32];
                        end
                        if (bus.in_bias_en) begin
                            state <= ISSUE;
                        end else begin
                            for (int i = 0; i < N_COL; i++) out_buf[i] <= bus.in_acc[32*i +: 32];
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end
                    end
                end
                ISSUE: begin
                    add_a <= acc_r[sel];
                    add_b <= bias_r[sel];
                    if (!bus.add_busy) begin
                        add_start <= 1'b1;
                        state     <= ARM;
                    end
                end
                // add_done may still be high from the previous lane until the driver takes this start
                ARM: state <= WAIT;
                WAIT: begin
                    if (bus.add_done) begin
                        out_buf[sel] <= bus.add_z;
                        if (lane == LAST) begin
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            lane  <= lane + 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bias_add_row_seq.sv
// tb/tb_bias_add_row_seq.sv - directed bench for bias_add_row_seq with a behavioural adder driver
module tb_bias_add_row_seq;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold_busy = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   busy_viol = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_z = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    int          m_cnt = 0;

    bias_add_row_seq_if #(.N_COL(N)) bus ();
    bias_add_row_seq #(.N_COL(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Zero and normal FP32 values only; that covers every vector used here.
    function automatic real f2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:0] == 31'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    assign bus.add_busy = m_busy | hold_busy;
    assign bus.add_done = m_done;
    assign bus.add_z    = m_z;

    // Adder driver: 3-cycle busy window, done stays high until the next accepted start.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_z    <= '0;
            m_cnt  <= 0;
        end else if (bus.add_start && !bus.add_busy) begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_cnt  <= 3;
            m_a    <= bus.add_a;
            m_b    <= bus.add_b;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_z    <= fadd(m_a, m_b);
            end
            m_cnt <= m_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (bus.add_start) begin
            qa.push_back(bus.add_a);
            qb.push_back(bus.add_b);
            if (bus.add_busy) busy_viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [127:0] acc, input logic [127:0] bias, input logic en);
        int n;
        n = 0;
        bus.in_valid   = 1'b1;
        bus.in_acc     = acc;
        bus.in_bias    = bias;
        bus.in_bias_en = en;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("accept_wait", n < 100, 1'b1);
        tick();
        bus.in_valid   = 1'b0;
        bus.in_acc     = ~acc;
        bus.in_bias    = ~bias;
        bus.in_bias_en = ~en;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
    endtask

    task automatic take_out(input string tag, input logic [127:0] exp);
        wait_valid(tag);
        chk({tag, "_data"}, bus.out_data, exp);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_drop"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] acc1, bias1, exp1, acc2, bias2, exp2, acc3, acc5, bias5, exp5, snap;
        logic         ok;
        int           n, qs;
        acc1  = {4{32'h3F800000}};
        bias1 = {4{32'h3F000000}};
        exp1  = {4{32'h3FC00000}};
        acc2  = {32'h41200000, 32'h40400000, 32'h3F800000, 32'hC0000000};
        bias2 = {32'h40A00000, 32'h3F800000, 32'h40000000, 32'h40000000};
        exp2  = {32'h41700000, 32'h40800000, 32'h40400000, 32'h00000000};
        acc3  = {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h55AA55AA};
        acc5  = {4{32'h40000000}};
        bias5 = {4{32'h3F800000}};
        exp5  = {4{32'h40400000}};

        bus.in_valid = 1'b0; bus.in_acc = '0; bus.in_bias = '0; bus.in_bias_en = 1'b0; bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_add", {bus.add_start, bus.add_a, bus.add_b}, '0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", bus.in_ready, 1'b1);

        // 1.0 + 0.5 on every lane, with the driver busy for a while after accept
        qa.delete(); qb.delete();
        hold_busy = 1'b1;
        accept(acc1, bias1, 1'b1);
        repeat (4) tick();
        chk("t1_busy_hold", qa.size(), 0);
        hold_busy = 1'b0;
        take_out("t1", exp1);
        chk("t1_starts", qa.size(), 4);

        qa.delete(); qb.delete();
        accept(acc2, bias2, 1'b1);
        wait_valid("t2");
        chk("t2_lane0_zero", bus.out_data[31:0], 32'h00000000);
        for (int i = 1; i < N; i++)
            chk("t2_lane_ref", bus.out_data[32*i +: 32], fadd(acc2[32*i +: 32], bias2[32*i +: 32]));
        take_out("t2", exp2);
        chk("t2_starts", qa.size(), 4);
        chk("t2_a_order", {qa[3], qa[2], qa[1], qa[0]}, acc2);
        chk("t2_b_order", {qb[3], qb[2], qb[1], qb[0]}, bias2);

        // Pass-through row: visible the cycle after accept, adder untouched
        qa.delete(); qb.delete();
        accept(acc3, bias2, 1'b0);
        chk("t3_lat_valid", bus.out_valid, 1'b1);
        chk("t3_lat_data", bus.out_data, acc3);
        take_out("t3", acc3);
        chk("t3_no_start", qa.size(), 0);

        // Downstream stall for 20 cycles
        accept(acc2, bias2, 1'b1);
        wait_valid("t4");
        qs = qa.size();
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (bus.out_data !== exp2 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) ok = 1'b0;
        end
        chk("t4_stable", ok, 1'b1);
        chk("t4_no_start", qa.size(), qs);
        take_out("t4", exp2);

        // Back-to-back rows with in_valid held high
        qa.delete(); qb.delete();
        bus.in_valid = 1'b1; bus.in_acc = acc5; bus.in_bias = bias5; bus.in_bias_en = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin tick(); n++; end
        tick();
        bus.in_acc = acc2; bus.in_bias = bias2;
        ok = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            if (bus.in_ready !== 1'b0) ok = 1'b0;
            tick();
            n++;
        end
        chk("t5_no_early_accept", ok, 1'b1);
        chk("t5a_data", bus.out_data, exp5);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t5_idle_after_handoff", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("t5b_accepted", bus.in_ready, 1'b0);
        take_out("t5b", exp2);
        chk("t5_starts", qa.size(), 8);
        chk("t5b_a_order", {qa[7], qa[6], qa[5], qa[4]}, acc2);

        // Reset right after the lane-2 start
        qa.delete(); qb.delete();
        accept(acc2, bias2, 1'b1);
        n = 0;
        while (!(bus.add_start && qa.size() == 2) && n < 200) begin tick(); n++; end
        chk("t6_reach_lane2", n < 200, 1'b1);
        rst = 1'b1;
        tick();
        chk("t6_out_valid", bus.out_valid, 1'b0);
        chk("t6_start_cleared", bus.add_start, 1'b0);
        rst = 1'b0;
        repeat (10) tick();
        chk("t6_idle", bus.in_ready, 1'b1);
        chk("t6_no_more_starts", qa.size(), 3);
        accept(acc1, bias1, 1'b1);
        take_out("t6_after", exp1);

        chk("busy_violations", busy_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
